ir_nec_decoder: RTL and testbench

IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

---
 rtl/ir_nec_decoder.sv | 176 +++++++++++++++++
 tb/tb_ir_nec_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder: synchronises the demodulated receiver line, times each
// mark/space in microseconds and decodes 32-bit frames and repeat codes.
module ir_nec_decoder #(
  parameter int TICKS_PER_US = 25,
  parameter bit STRICT_ADDR  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        ir_rx,
  output logic        frame_valid,
  output logic        repeat_valid,
  output logic        err,
  output logic [15:0] addr,
  output logic [7:0]  cmd
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_RPT_STOP
  } state_t;

  localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_US - 1);

  localparam logic [13:0] LM_MIN  = 14'd8000, LM_MAX  = 14'd10000;
  localparam logic [13:0] LS_MIN  = 14'd4000, LS_MAX  = 14'd5000;
  localparam logic [13:0] RS_MIN  = 14'd1750, RS_MAX  = 14'd2750;
  localparam logic [13:0] SH_MIN  = 14'd400,  SH_MAX  = 14'd700;
  localparam logic [13:0] ONE_MIN = 14'd1400, ONE_MAX = 14'd1900;

  state_t             r_state, w_next;
  logic               r_sync1, r_sync2, r_sync3;
  logic [PRE_W-1:0]   r_pre;
  logic [13:0]        r_width;
  logic [4:0]         r_bit_idx;
  logic [31:0]        r_shift;
  logic               r_have_frame;
  logic [15:0]        r_addr;
  logic [7:0]         r_cmd;
  logic               r_frame_valid, r_repeat_valid, r_err;

  logic               w_tick, w_rise, w_fall, w_edge;
  logic               w_err_ev, w_frame_ev, w_rpt_ev, w_shift_en, w_shift_bit, w_frame_ok;
  logic [13:0]        w_max;

  function automatic logic in_rng(input logic [13:0] w, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  assign w_tick     = (r_pre == PRE_LAST);
  assign w_rise     = r_sync2 & ~r_sync3;
  assign w_fall     = ~r_sync2 & r_sync3;
  assign w_edge     = w_rise | w_fall;
  assign w_frame_ok = (r_shift[31:24] == ~r_shift[23:16]) &&
                      (!STRICT_ADDR || (r_shift[15:8] == ~r_shift[7:0]));

  // NOTE: sync flops reset to 1 (idle line) so reset release never fakes a falling edge.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
      r_pre   <= '0;
      r_width <= '0;
    end else begin
      r_sync1 <= ir_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pre   <= w_tick ? '0 : r_pre + 1'b1;
      if (w_edge)                    r_width <= '0;
      else if (w_tick && ~&r_width)  r_width <= r_width + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Event decode: every edge is the one the current phase expects, since edges alternate.
  always_comb begin
    w_err_ev    = 1'b0;
    w_frame_ev  = 1'b0;
    w_rpt_ev    = 1'b0;
    w_shift_en  = 1'b0;
    w_shift_bit = 1'b0;
    w_max       = SH_MAX;
    unique case (r_state)
      S_IDLE:       w_max = '1;
      S_LEAD_MARK: begin
        w_max = LM_MAX;
        if (w_rise) w_err_ev = !in_rng(r_width, LM_MIN, LM_MAX);
      end
      S_LEAD_SPACE: begin
        w_max = LS_MAX;
        if (w_fall) w_err_ev = !in_rng(r_width, LS_MIN, LS_MAX) &&
                               !in_rng(r_width, RS_MIN, RS_MAX);
      end
      S_BIT_MARK: begin
        if (w_rise) w_err_ev = !in_rng(r_width, SH_MIN, SH_MAX);
      end
      S_BIT_SPACE: begin
        w_max = ONE_MAX;
        if (w_fall) begin
          w_shift_bit = in_rng(r_width, ONE_MIN, ONE_MAX);
          w_shift_en  = w_shift_bit || in_rng(r_width, SH_MIN, SH_MAX);
          w_err_ev    = !w_shift_en;
        end
      end
      S_STOP_MARK: begin
        if (w_rise) begin
          w_frame_ev = in_rng(r_width, SH_MIN, SH_MAX) && w_frame_ok;
          w_err_ev   = !w_frame_ev;
        end
      end
      S_RPT_STOP: begin
        if (w_rise) begin
          w_rpt_ev = in_rng(r_width, SH_MIN, SH_MAX) && r_have_frame;
          w_err_ev = !w_rpt_ev;
        end
      end
      default: w_err_ev = 1'b1;
    endcase
    if (r_state != S_IDLE && !w_edge && r_width > w_max) w_err_ev = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    if (w_err_ev) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:       if (w_fall) w_next = S_LEAD_MARK;
        S_LEAD_MARK:  if (w_rise) w_next = S_LEAD_SPACE;
        S_LEAD_SPACE: if (w_fall) w_next = in_rng(r_width, LS_MIN, LS_MAX) ? S_BIT_MARK
                                                                           : S_RPT_STOP;
        S_BIT_MARK:   if (w_rise) w_next = S_BIT_SPACE;
        S_BIT_SPACE:  if (w_fall) w_next = (r_bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
        S_STOP_MARK, S_RPT_STOP: if (w_rise) w_next = S_IDLE;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_bit_idx      <= '0;
      r_shift        <= '0;
      r_have_frame   <= 1'b0;
      r_addr         <= '0;
      r_cmd          <= '0;
      r_frame_valid  <= 1'b0;
      r_repeat_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      if (r_state == S_LEAD_SPACE && w_fall) r_bit_idx <= '0;
      else if (w_shift_en)                   r_bit_idx <= r_bit_idx + 1'b1;
      if (w_shift_en) r_shift <= {w_shift_bit, r_shift[31:1]};
      if (w_frame_ev) begin
        r_addr       <= r_shift[15:0];
        r_cmd        <= r_shift[23:16];
        r_have_frame <= 1'b1;
      end
      r_frame_valid  <= w_frame_ev;
      r_repeat_valid <= w_rpt_ev;
      r_err          <= w_err_ev;
    end
  end

  assign frame_valid  = r_frame_valid;
  assign repeat_valid = r_repeat_valid;
  assign err          = r_err;
  assign addr         = r_addr;
  assign cmd          = r_cmd;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder: good frames, repeats, bad complement, space timeout,
// mid-frame reset. One microsecond is 2 clocks of 10 ns (TICKS_PER_US = 2).
module tb_ir_nec_decoder;

  localparam int US_NS = 20;

  logic        clk = 1'b0;
  logic        reset_;
  logic        ir_rx;
  logic        frame_valid, repeat_valid, err;
  logic [15:0] addr;
  logic [7:0]  cmd;

  int  n_vec = 0, n_bad = 0;
  int  n_fv = 0, n_rv = 0, n_err = 0, n_overlap = 0;
  time t_err = 0;

  ir_nec_decoder #(.TICKS_PER_US(2), .STRICT_ADDR(1'b1)) dut (
    .clk(clk), .reset_(reset_), .ir_rx(ir_rx),
    .frame_valid(frame_valid), .repeat_valid(repeat_valid), .err(err),
    .addr(addr), .cmd(cmd)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the rising edge.
  always @(negedge clk) begin
    if (frame_valid)  n_fv++;
    if (repeat_valid) n_rv++;
    if (err) begin
      n_err++;
      t_err = $time;
    end
    if (int'(frame_valid) + int'(repeat_valid) + int'(err) > 1) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic line(input logic v, input int us);
    ir_rx = v;
    #(us * US_NS);
  endtask

  task automatic send_bits(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      line(1'b0, 450);
      line(1'b1, d[i] ? 1450 : 450);
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    line(1'b0, 8500);
    line(1'b1, 4200);
    send_bits({b3, b2, b1, b0}, 32);
    line(1'b0, 450);
    line(1'b1, 100);
  endtask

  task automatic send_repeat();
    line(1'b0, 9000);
    line(1'b1, 2250);
    line(1'b0, 562);
    line(1'b1, 100);
  endtask

  initial begin
    int  fv0, rv0, er0;
    time t0, d;

    reset_ = 1'b0;
    ir_rx  = 1'b1;
    #100;
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_pulses", {29'd0, frame_valid, repeat_valid, err}, 32'h0);
    reset_ = 1'b1;
    #200;

    fv0 = n_fv; rv0 = n_rv; er0 = n_err;
    send_repeat();
    check("rpt_no_frame_err", 32'(n_err - er0), 32'd1);
    check("rpt_no_frame_rv", 32'(n_rv - rv0), 32'd0);

    fv0 = n_fv; er0 = n_err;
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
    check("frame1_fv", 32'(n_fv - fv0), 32'd1);
    check("frame1_err", 32'(n_err - er0), 32'd0);
    check("frame1_addr", 32'(addr), 32'hFF00);
    check("frame1_cmd", 32'(cmd), 32'h45);

    rv0 = n_rv; er0 = n_err;
    send_repeat();
    check("rpt_rv", 32'(n_rv - rv0), 32'd1);
    check("rpt_err", 32'(n_err - er0), 32'd0);
    check("rpt_addr", 32'(addr), 32'hFF00);
    check("rpt_cmd", 32'(cmd), 32'h45);

    fv0 = n_fv; er0 = n_err;
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBB);
    check("badcmp_err", 32'(n_err - er0), 32'd1);
    check("badcmp_fv", 32'(n_fv - fv0), 32'd0);
    check("badcmp_addr", 32'(addr), 32'hFF00);
    check("badcmp_cmd", 32'(cmd), 32'h45);

    // Bit 10 space held high for 3 ms: expect a timeout just past 1900 us.
    fv0 = n_fv; er0 = n_err;
    line(1'b0, 8500);
    line(1'b1, 4200);
    send_bits(32'hE916FF00, 10);
    line(1'b0, 450);
    t0 = $time;
    line(1'b1, 3000);
    d = t_err - t0;
    check("tmo_err", 32'(n_err - er0), 32'd1);
    check("tmo_fv", 32'(n_fv - fv0), 32'd0);
    check("tmo_latency_ok", 32'(d >= 1900 * US_NS && d <= 1903 * US_NS), 32'd1);
    if (!(d >= 1900 * US_NS && d <= 1903 * US_NS))
      $display("  timeout latency %0t ns", d);

    fv0 = n_fv; er0 = n_err;
    send_frame(8'h00, 8'hFF, 8'h16, 8'hE9);
    check("after_tmo_fv", 32'(n_fv - fv0), 32'd1);
    check("after_tmo_err", 32'(n_err - er0), 32'd0);
    check("after_tmo_cmd", 32'(cmd), 32'h16);

    // Reset asserted in the middle of bit 20's mark.
    fv0 = n_fv; rv0 = n_rv; er0 = n_err;
    line(1'b0, 8500);
    line(1'b1, 4200);
    send_bits(32'hA55AEF10, 20);
    line(1'b0, 200);
    reset_ = 1'b0;
    #(5 * US_NS);
    check("midrst_addr", 32'(addr), 32'h0);
    check("midrst_cmd", 32'(cmd), 32'h0);
    ir_rx = 1'b1;
    #(20 * US_NS);
    reset_ = 1'b1;
    #(100 * US_NS);
    check("midrst_pulses", 32'((n_fv - fv0) + (n_rv - rv0) + (n_err - er0)), 32'd0);

    fv0 = n_fv; er0 = n_err;
    send_frame(8'h10, 8'hEF, 8'h5A, 8'hA5);
    check("after_rst_fv", 32'(n_fv - fv0), 32'd1);
    check("after_rst_err", 32'(n_err - er0), 32'd0);
    check("after_rst_addr", 32'(addr), 32'hEF10);
    check("after_rst_cmd", 32'(cmd), 32'h5A);

    check("pulse_overlap", 32'(n_overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
